// File: rtl/axis_loopback_pkg.sv
// Shared definitions for the AXI4-Stream loopback block: CSR byte offsets,
// CTRL bit positions and layout, CTRL reset value and the CSR FSM state types.
// Latency / backpressure: not applicable (definitions only).
package axis_loopback_pkg;

   localparam logic [3:0] CTRL_OFS     = 4'h0;
   localparam logic [3:0] STATUS_OFS   = 4'h4;
   localparam logic [3:0] XOR_MASK_OFS = 4'h8;
   localparam logic [3:0] PKT_CNT_OFS  = 4'hC;

   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_FLUSH_BIT  = 1;

   // FLUSH is a write-only strobe; the stored copy is always 0 so it reads back 0.
   typedef struct packed {
      logic flush;
      logic enable;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{flush: 1'b0, enable: 1'b1};

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush.
// Latency: a word pushed in cycle N is visible on pop_data/!empty in cycle N+1.
// Backpressure: push is ignored while full, pop is ignored while empty; flush wins over both.
// Ports: clk, rst (async, active-high), push/push_data, pop/pop_data, flush, full, empty, level.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level    = wr_ptr - rd_ptr;
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/axis_loopback_fifo.sv
// H2C->C2H AXI4-Stream loopback through an FWFT FIFO, with an AXI4-Lite CSR bank (enable, flush, XOR mask, status).
// Latency: H2C beat accepted in cycle N is offered on C2H in N+1; CSR bvalid/rvalid one cycle after acceptance.
// Backpressure: H2C tready low when full, disabled or flushing; C2H word held while tvalid && !tready.
// Ports: AXI_clock, AXI_reset (async, active-high); AXIL_* AXI4-Lite slave; AXIS_H2C_* in; AXIS_C2H_* out.
// Optional: define AXIS_LOOPBACK_STATS_EN to implement the PKT_CNT counter at offset 0xC (reads 0 otherwise).
module axis_loopback_fifo
   import axis_loopback_pkg::*;
#(
   parameter int AXIL_DATA_WIDTH    = 32,
   parameter int AXIL_ADDRESS_WIDTH = 4,
   parameter int TDATA_WIDTH        = 64,
   parameter int FIFO_DEPTH         = 16
) (
   input  logic                          AXI_clock,
   input  logic                          AXI_reset,
   input  logic [AXIL_ADDRESS_WIDTH-1:0] AXIL_awaddr,
   input  logic [2:0]                    AXIL_awprot,
   input  logic                          AXIL_awvalid,
   output logic                          AXIL_awready,
   input  logic [AXIL_DATA_WIDTH-1:0]    AXIL_wdata,
   input  logic [AXIL_DATA_WIDTH/8-1:0]  AXIL_wstrb,
   input  logic                          AXIL_wvalid,
   output logic                          AXIL_wready,
   output logic [1:0]                    AXIL_bresp,
   output logic                          AXIL_bvalid,
   input  logic                          AXIL_bready,
   input  logic [AXIL_ADDRESS_WIDTH-1:0] AXIL_araddr,
   input  logic [2:0]                    AXIL_arprot,
   input  logic                          AXIL_arvalid,
   output logic                          AXIL_arready,
   output logic [AXIL_DATA_WIDTH-1:0]    AXIL_rdata,
   output logic [1:0]                    AXIL_rresp,
   output logic                          AXIL_rvalid,
   input  logic                          AXIL_rready,
   input  logic [TDATA_WIDTH-1:0]        AXIS_H2C_tdata,
   input  logic [TDATA_WIDTH/8-1:0]      AXIS_H2C_tkeep,
   input  logic                          AXIS_H2C_tlast,
   input  logic                          AXIS_H2C_tvalid,
   output logic                          AXIS_H2C_tready,
   output logic [TDATA_WIDTH-1:0]        AXIS_C2H_tdata,
   output logic [TDATA_WIDTH/8-1:0]      AXIS_C2H_tkeep,
   output logic                          AXIS_C2H_tlast,
   output logic                          AXIS_C2H_tvalid,
   input  logic                          AXIS_C2H_tready
);
   localparam int ENTRY_WIDTH = 1 + TDATA_WIDTH/8 + TDATA_WIDTH;
   localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;
   localparam logic [AXIL_ADDRESS_WIDTH-1:0] CTRL_A    = AXIL_ADDRESS_WIDTH'(CTRL_OFS);
   localparam logic [AXIL_ADDRESS_WIDTH-1:0] STATUS_A  = AXIL_ADDRESS_WIDTH'(STATUS_OFS);
   localparam logic [AXIL_ADDRESS_WIDTH-1:0] XOR_A     = AXIL_ADDRESS_WIDTH'(XOR_MASK_OFS);
   localparam logic [AXIL_ADDRESS_WIDTH-1:0] PKT_CNT_A = AXIL_ADDRESS_WIDTH'(PKT_CNT_OFS);

   wr_state_t                     wr_state, wr_state_nxt;
   rd_state_t                     rd_state, rd_state_nxt;
   ctrl_t                         ctrl_q;
   logic [31:0]                   xor_mask_q;
   logic [31:0]                   pkt_cnt;
   logic [31:0]                   rd_word;
   logic [31:0]                   rdata_q;
   logic                          wr_fire;
   logic                          rd_fire;
   logic                          flush_now;
   logic                          h2c_push;
   logic                          c2h_pop;
   logic [AXIL_ADDRESS_WIDTH-1:0] wr_addr;
   logic [AXIL_ADDRESS_WIDTH-1:0] rd_addr;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [LEVEL_WIDTH-1:0]        fifo_level;
   logic [ENTRY_WIDTH-1:0]        fifo_in;
   logic [ENTRY_WIDTH-1:0]        fifo_out;
   logic                          unused_inputs;

   // Registers are word-aligned; byte-lane address bits and prot are don't-care.
   assign wr_addr       = {AXIL_awaddr[AXIL_ADDRESS_WIDTH-1:2], 2'b00};
   assign rd_addr       = {AXIL_araddr[AXIL_ADDRESS_WIDTH-1:2], 2'b00};
   assign unused_inputs = ^{AXIL_awprot, AXIL_arprot, AXIL_awaddr[1:0], AXIL_araddr[1:0]};

   // ---------------- CSR FSMs ----------------
   always_ff @(posedge AXI_clock or posedge AXI_reset) begin
      if (AXI_reset) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
      end else begin
         wr_state <= wr_state_nxt;
         rd_state <= rd_state_nxt;
      end
   end

   always_comb begin
      wr_state_nxt = wr_state;
      wr_fire      = 1'b0;
      AXIL_bvalid  = 1'b0;
      case (wr_state)
         WR_IDLE: if (AXIL_awvalid && AXIL_wvalid && !AXI_reset) begin
            wr_fire      = 1'b1;
            wr_state_nxt = WR_RESP;
         end
         WR_RESP: begin
            AXIL_bvalid = 1'b1;
            if (AXIL_bready) wr_state_nxt = WR_IDLE;
         end
         default: wr_state_nxt = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_state_nxt = rd_state;
      rd_fire      = 1'b0;
      AXIL_arready = 1'b0;
      AXIL_rvalid  = 1'b0;
      case (rd_state)
         RD_IDLE: begin
            AXIL_arready = !AXI_reset;
            if (AXIL_arvalid && !AXI_reset) begin
               rd_fire      = 1'b1;
               rd_state_nxt = RD_DATA;
            end
         end
         RD_DATA: begin
            AXIL_rvalid = 1'b1;
            if (AXIL_rready) rd_state_nxt = RD_IDLE;
         end
         default: rd_state_nxt = RD_IDLE;
      endcase
   end

   assign AXIL_awready = wr_fire;
   assign AXIL_wready  = wr_fire;
   assign AXIL_bresp   = 2'b00;
   assign AXIL_rresp   = 2'b00;
   assign AXIL_rdata   = rdata_q;

   // ---------------- CSR registers ----------------
   always_ff @(posedge AXI_clock or posedge AXI_reset) begin
      if (AXI_reset) begin
         ctrl_q     <= CTRL_RESET;
         xor_mask_q <= '0;
      end else if (wr_fire) begin
         if (wr_addr == CTRL_A && AXIL_wstrb[0]) ctrl_q.enable <= AXIL_wdata[CTRL_ENABLE_BIT];
         if (wr_addr == XOR_A) begin
            for (int b = 0; b < 4; b++) begin
               if (AXIL_wstrb[b]) xor_mask_q[8*b +: 8] <= AXIL_wdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_addr == CTRL_A) begin
         rd_word = {30'd0, ctrl_q};
      end else if (rd_addr == STATUS_A) begin
         rd_word[10:0] = 11'(fifo_level);
         rd_word[16]   = fifo_empty;
         rd_word[17]   = fifo_full;
      end else if (rd_addr == XOR_A) begin
         rd_word = xor_mask_q;
      end else if (rd_addr == PKT_CNT_A) begin
         rd_word = pkt_cnt;
      end
   end

   always_ff @(posedge AXI_clock or posedge AXI_reset) begin
      if (AXI_reset)    rdata_q <= '0;
      else if (rd_fire) rdata_q <= rd_word;
   end

   // ---------------- Stream path ----------------
   // Flush acts on the edge that accepts the CTRL write, so the pointers are already
   // zero the following cycle; H2C is held off in that cycle so no beat is lost silently.
   assign flush_now = wr_fire && (wr_addr == CTRL_A) && AXIL_wstrb[0] && AXIL_wdata[CTRL_FLUSH_BIT];

   assign AXIS_H2C_tready = !AXI_reset && ctrl_q.enable && !fifo_full && !flush_now;
   assign h2c_push        = AXIS_H2C_tvalid && AXIS_H2C_tready;
   assign AXIS_C2H_tvalid = !fifo_empty;
   assign c2h_pop         = AXIS_C2H_tvalid && AXIS_C2H_tready;

   // The mask is applied on entry so later mask writes never alter buffered beats.
   assign fifo_in = {AXIS_H2C_tlast, AXIS_H2C_tkeep,
                     AXIS_H2C_tdata ^ {(TDATA_WIDTH/32){xor_mask_q}}};
   assign {AXIS_C2H_tlast, AXIS_C2H_tkeep, AXIS_C2H_tdata} = fifo_out;

   sync_fifo_fwft #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (AXI_clock),
      .rst       (AXI_reset),
      .push      (h2c_push),
      .push_data (fifo_in),
      .pop       (c2h_pop),
      .flush     (flush_now),
      .pop_data  (fifo_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // ---------------- Packet counter ----------------
`ifdef AXIS_LOOPBACK_STATS_EN
   logic [31:0] pkt_cnt_q;

   // Any write clears; a flush leaves it alone.
   always_ff @(posedge AXI_clock or posedge AXI_reset) begin
      if (AXI_reset)                             pkt_cnt_q <= '0;
      else if (wr_fire && wr_addr == PKT_CNT_A)  pkt_cnt_q <= '0;
      else if (c2h_pop && AXIS_C2H_tlast)        pkt_cnt_q <= pkt_cnt_q + 32'd1;
   end

   assign pkt_cnt = pkt_cnt_q;
`else
   assign pkt_cnt = '0;
`endif

endmodule
